// File: rtl/mode_key_encoder_pkg.sv
// Mode request codes and key count shared by the key encoder and the mode controller.
package mode_key_encoder_pkg;

  localparam int NUM_MODE_KEYS = 4;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_S1   = 2'b01,
    MODE_S2   = 2'b10,
    MODE_S3   = 2'b11
  } mode_code_e;

  // Lowest asserted index wins, so IDLE (key 0) always beats the other modes.
  function automatic mode_code_e key_to_mode(input logic [NUM_MODE_KEYS-1:0] press);
    mode_code_e code;
    logic [31:0] idx;
    code = MODE_IDLE;
    for (int i = NUM_MODE_KEYS - 1; i >= 0; i--) begin
      idx = i;
      if (press[i]) code = mode_code_e'(idx[1:0]);
    end
    return code;
  endfunction

endpackage

// File: rtl/mode_key_encoder_if.sv
// Key inputs and mode request outputs between the board keys and the mode controller.
interface mode_key_encoder_if;
  import mode_key_encoder_pkg::*;

  logic [NUM_MODE_KEYS-1:0] key_n;
  mode_code_e               req_code;
  logic                     req_valid;
  logic                     key_active;

  modport master (output key_n, input req_code, input req_valid, input key_active);
  modport slave  (input key_n, output req_code, output req_valid, output key_active);

endinterface

// File: rtl/mode_key_encoder_key_debounce.sv
// Synchroniser plus debounce counter for one active-low key; flags the cycle after
// the debounced level falls (press). Release edges are only visible via o_stable.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_stable,
  output logic o_press
);

  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("key_debounce: DEBOUNCE_CYCLES must be at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("key_debounce: SYNC_STAGES must be at least 2");
    end
  endgenerate

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;
  logic                   r_stable_d;
  logic                   w_sample;

  assign w_sample = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync     <= '1;
      r_cnt      <= '0;
      r_stable   <= 1'b1;
      r_stable_d <= 1'b1;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], i_key_n};
      r_stable_d <= r_stable;
      // Counter saturates at CNT_MAX; the next differing sample commits the new level.
      if (w_sample == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_stable <= ~r_stable;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_stable = r_stable;
  assign o_press  = r_stable_d & ~r_stable;

endmodule

// File: rtl/mode_key_encoder.sv
// Debounces four mode keys and turns each press into a held 2-bit request code
// with a one-cycle strobe; all outputs are registered.
module mode_key_encoder
  import mode_key_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  mode_key_encoder_if.slave  io_keys
);

  logic [NUM_MODE_KEYS-1:0] w_stable;
  logic [NUM_MODE_KEYS-1:0] w_press;

  mode_code_e r_req_code;
  logic       r_req_valid;
  logic       r_key_active;

  genvar g;
  generate
    for (g = 0; g < NUM_MODE_KEYS; g++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
      ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_key_n  (io_keys.key_n[g]),
        .o_stable (w_stable[g]),
        .o_press  (w_press[g])
      );
    end
  endgenerate

  // Simultaneous presses collapse to one strobe for the highest-priority key.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req_code   <= MODE_IDLE;
      r_req_valid  <= 1'b0;
      r_key_active <= 1'b0;
    end else begin
      r_req_valid  <= |w_press;
      r_key_active <= |(~w_stable);
      if (|w_press) r_req_code <= key_to_mode(w_press);
    end
  end

  assign io_keys.req_code   = r_req_code;
  assign io_keys.req_valid  = r_req_valid;
  assign io_keys.key_active = r_key_active;

endmodule

// File: tb/tb_mode_key_encoder.sv
// Directed plan plus random key traffic, every cycle compared against a sample-history model.
module tb_mode_key_encoder;
  import mode_key_encoder_pkg::*;

  localparam int DEB  = 4;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n;
  mode_key_encoder_if bus ();

  mode_key_encoder #(
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYNC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .io_keys (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: raw samples reach the debouncer SYNC edges late; a key's level flips after
  // DEB consecutive samples disagree with it; outputs react one edge after the flip.
  bit         m_hist   [4][SYNC];
  bit         m_stable [4];
  bit         m_old    [4];
  int         m_run    [4];
  logic [1:0] e_code;
  bit         e_valid;
  bit         e_active;

  task automatic model_edge(input logic [3:0] k, input bit rst);
    int first;
    bit samp;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        for (int s = 0; s < SYNC; s++) m_hist[i][s] = 1'b1;
        m_stable[i] = 1'b1;
        m_old[i]    = 1'b1;
        m_run[i]    = 0;
      end
      e_code = 2'b00; e_valid = 1'b0; e_active = 1'b0;
      return;
    end
    first = -1;
    e_active = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_old[i] && !m_stable[i] && first < 0) first = i;
      if (!m_stable[i]) e_active = 1'b1;
    end
    e_valid = (first >= 0);
    if (e_valid) e_code = first[1:0];
    for (int i = 0; i < 4; i++) begin
      m_old[i] = m_stable[i];
      samp = m_hist[i][SYNC-1];
      for (int s = SYNC - 1; s > 0; s--) m_hist[i][s] = m_hist[i][s-1];
      m_hist[i][0] = k[i];
      if (samp != m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_stable[i] = ~m_stable[i];
          m_run[i]    = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  int n_strobe;
  int edge_cnt;
  int first_strobe;

  task automatic clear_counts();
    n_strobe = 0; edge_cnt = 0; first_strobe = -1;
  endtask

  task automatic step(input logic [3:0] k, input bit rst);
    bus.key_n = k;
    rst_n     = !rst;
    @(posedge clk);
    model_edge(k, rst);
    #1;
    edge_cnt++;
    check("req_code",   bus.req_code,   e_code);
    check("req_valid",  bus.req_valid,  e_valid);
    check("key_active", bus.key_active, e_active);
    if (bus.req_valid) begin
      n_strobe++;
      if (first_strobe < 0) first_strobe = edge_cnt;
    end
  endtask

  initial begin
    logic [3:0] cur;
    logic [3:0] drv;
    int r;

    bus.key_n = 4'hF;
    rst_n = 1'b0;
    step(4'hF, 1'b1);
    step(4'hF, 1'b1);
    check("reset_code",   bus.req_code,   32'd0);
    check("reset_active", bus.key_active, 32'd0);

    // Idle keys
    clear_counts();
    repeat (20) step(4'hF, 1'b0);
    check("idle_strobes", n_strobe, 32'd0);

    // Single press of key 1, then release
    clear_counts();
    repeat (10) step(4'b1101, 1'b0);
    check("s1_strobe_edge",  first_strobe, 32'd7);
    check("s1_strobe_count", n_strobe,     32'd1);
    check("s1_code",         bus.req_code, 32'd1);
    check("s1_active",       bus.key_active, 32'd1);
    clear_counts();
    repeat (10) step(4'hF, 1'b0);
    check("s1_release_strobes", n_strobe, 32'd0);
    check("s1_release_code",    bus.req_code, 32'd1);
    check("s1_release_active",  bus.key_active, 32'd0);

    // Bouncing key 2, then held
    clear_counts();
    for (int i = 0; i < 12; i++) step(((i / 2) % 2 == 0) ? 4'b1011 : 4'b1111, 1'b0);
    check("bounce_strobes", n_strobe, 32'd0);
    clear_counts();
    repeat (10) step(4'b1011, 1'b0);
    check("bounce_strobe_edge", first_strobe, 32'd7);
    check("bounce_code",        bus.req_code, 32'd2);
    repeat (10) step(4'hF, 1'b0);

    // Keys 3 and 0 together: key 0 wins
    clear_counts();
    repeat (10) step(4'b0110, 1'b0);
    check("simul_strobes", n_strobe,       32'd1);
    check("simul_code",    bus.req_code,   32'd0);
    check("simul_active",  bus.key_active, 32'd1);
    repeat (10) step(4'hF, 1'b0);

    // Key 1 held, key 3 added, then key 3 re-pressed
    repeat (10) step(4'b1101, 1'b0);
    clear_counts();
    repeat (10) step(4'b0101, 1'b0);
    check("overlap_strobes", n_strobe,     32'd1);
    check("overlap_code",    bus.req_code, 32'd3);
    repeat (10) step(4'b1101, 1'b0);
    clear_counts();
    repeat (10) step(4'b0101, 1'b0);
    check("repress_strobes", n_strobe,     32'd1);
    check("repress_code",    bus.req_code, 32'd3);
    repeat (10) step(4'hF, 1'b0);

    // Reset in the middle of debouncing key 2
    clear_counts();
    repeat (3) step(4'b1011, 1'b0);
    check("midrst_pre_strobes", n_strobe, 32'd0);
    step(4'b1011, 1'b1);
    check("midrst_code", bus.req_code, 32'd0);
    clear_counts();
    repeat (10) step(4'b1011, 1'b0);
    check("midrst_strobe_edge", first_strobe, 32'd7);
    check("midrst_code_after",  bus.req_code, 32'd2);
    repeat (10) step(4'hF, 1'b0);

    // Random keys with glitches and occasional resets
    cur = 4'hF;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 199);
      if (r < 25) cur[$urandom_range(0, 3)] ^= 1'b1;
      drv = cur;
      if (r >= 25 && r < 33) drv[$urandom_range(0, 3)] ^= 1'b1;
      step(drv, r == 199);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
